// File: rtl/puf_challenge_sequencer_if.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer_if
// Result handshake between the PUF challenge sequencer and the host.
//   resp_valid      sequencer -> host  result available
//   resp_ready      host -> sequencer  host accepts result
//   resp_challenge  sequencer -> host  challenge that produced the result
//   resp_data       sequencer -> host  majority-voted response
//   resp_unstable   sequencer -> host  per-bit instability flags
// master: the sequencer side, slave: the host side.
// ---------------------------------------------------------------------------
interface puf_challenge_sequencer_if;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_challenge;
   logic [7:0] resp_data;
   logic [7:0] resp_unstable;

   modport master (
      output resp_valid,
      output resp_challenge,
      output resp_data,
      output resp_unstable,
      input  resp_ready
   );

   modport slave (
      input  resp_valid,
      input  resp_challenge,
      input  resp_data,
      input  resp_unstable,
      output resp_ready
   );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer
// Drives an 8-bit arbiter PUF array. Each measurement applies an LFSR
// generated challenge, fires NUM_SAMPLES excitation pulses, samples the
// (synchronized) response after each pulse, then majority-votes every bit
// and flags bits that did not agree on every sample.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   start          begin one measurement (only honoured in IDLE)
//   continuous     at handshake, 1 = start the next challenge immediately
//   load_seed      load seed into the LFSR (only honoured in IDLE)
//   seed           LFSR seed; 0 is replaced by 8'h01
//   puf_challenge  registered challenge to the PUF array
//   puf_pulse      registered excitation pulse to the PUF delay lines
//   puf_response   PUF response, asynchronous to clk
//   busy           high in every state except IDLE
//   resp           result handshake (master side of the interface)
// ---------------------------------------------------------------------------
module puf_challenge_sequencer #(
   parameter int NUM_SAMPLES   = 7,
   parameter int SETTLE_CYCLES = 4,
   parameter int PULSE_CYCLES  = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              continuous,
   input  logic                              load_seed,
   input  logic [7:0]                        seed,
   output logic [7:0]                        puf_challenge,
   output logic                              puf_pulse,
   input  logic [7:0]                        puf_response,
   output logic                              busy,
   puf_challenge_sequencer_if.master         resp
);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      PULSE,
      WAIT,
      SAMPLE,
      DONE
   } state_t;

   state_t     state;
   logic [7:0] lfsr;
   logic [7:0] phase_cnt;
   logic [3:0] sample_cnt;
   logic [3:0] ones [0:7];
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [7:0] vote_data;
   logic [7:0] vote_unstable;

   // Galois LFSR step, right shift with tap mask 8'hB8.
   function automatic logic [7:0] lfsr_next(input logic [7:0] value);
      return (value >> 1) ^ (value[0] ? 8'hB8 : 8'h00);
   endfunction

   // The PUF response is asynchronous; two flops before anything looks at it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= puf_response;
         sync2 <= sync1;
      end
   end

   // Majority vote and instability flags from the completed ones-counters.
   // With a single sample every count is 0 or NUM_SAMPLES, so nothing is
   // ever flagged unstable.
   always_comb begin
      vote_data     = 8'h00;
      vote_unstable = 8'h00;
      for (int i = 0; i < 8; i++) begin
         vote_data[i]     = (ones[i] > 4'(NUM_SAMPLES / 2));
         vote_unstable[i] = (ones[i] != 4'd0) && (ones[i] != 4'(NUM_SAMPLES));
      end
   end

   assign busy = (state != IDLE);

   // Measurement sequencer. DONE spends its first cycle latching the vote
   // (resp_valid still low), then holds the result until the host takes it.
   // The LFSR only moves on a completed transfer, so back-pressure never
   // skips a challenge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         lfsr                <= 8'h01;
         puf_challenge       <= 8'h00;
         puf_pulse           <= 1'b0;
         phase_cnt           <= 8'h00;
         sample_cnt          <= 4'h0;
         resp.resp_valid     <= 1'b0;
         resp.resp_data      <= 8'h00;
         resp.resp_challenge <= 8'h00;
         resp.resp_unstable  <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            ones[i] <= 4'h0;
         end
      end else begin
         case (state)
            IDLE: begin
               puf_pulse <= 1'b0;
               if (load_seed) begin
                  lfsr <= (seed == 8'h00) ? 8'h01 : seed;
               end else if (start) begin
                  state         <= APPLY;
                  puf_challenge <= lfsr;
                  phase_cnt     <= 8'h00;
                  sample_cnt    <= 4'h0;
                  for (int i = 0; i < 8; i++) begin
                     ones[i] <= 4'h0;
                  end
               end
            end

            APPLY: begin
               if (phase_cnt == 8'(SETTLE_CYCLES - 1)) begin
                  phase_cnt <= 8'h00;
                  puf_pulse <= 1'b1;
                  state     <= PULSE;
               end else begin
                  phase_cnt <= phase_cnt + 8'h01;
               end
            end

            PULSE: begin
               if (phase_cnt == 8'(PULSE_CYCLES - 1)) begin
                  phase_cnt <= 8'h00;
                  puf_pulse <= 1'b0;
                  state     <= WAIT;
               end else begin
                  phase_cnt <= phase_cnt + 8'h01;
               end
            end

            // Two extra cycles let the response cross the synchronizer.
            WAIT: begin
               if (phase_cnt == 8'(SETTLE_CYCLES + 1)) begin
                  phase_cnt <= 8'h00;
                  state     <= SAMPLE;
               end else begin
                  phase_cnt <= phase_cnt + 8'h01;
               end
            end

            SAMPLE: begin
               for (int i = 0; i < 8; i++) begin
                  ones[i] <= ones[i] + {3'b000, sync2[i]};
               end
               sample_cnt <= sample_cnt + 4'h1;
               if (sample_cnt == 4'(NUM_SAMPLES - 1)) begin
                  state <= DONE;
               end else begin
                  puf_pulse <= 1'b1;
                  state     <= PULSE;
               end
            end

            DONE: begin
               if (!resp.resp_valid) begin
                  resp.resp_valid     <= 1'b1;
                  resp.resp_data      <= vote_data;
                  resp.resp_unstable  <= vote_unstable;
                  resp.resp_challenge <= puf_challenge;
               end else if (resp.resp_ready) begin
                  resp.resp_valid <= 1'b0;
                  lfsr            <= lfsr_next(lfsr);
                  if (continuous) begin
                     state         <= APPLY;
                     puf_challenge <= lfsr_next(lfsr);
                     phase_cnt     <= 8'h00;
                     sample_cnt    <= 4'h0;
                     for (int i = 0; i < 8; i++) begin
                        ones[i] <= 4'h0;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               puf_pulse <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_puf_challenge_sequencer
// Self-checking bench for puf_challenge_sequencer. A small PUF model answers
// every excitation pulse and logs the value it presented; expected results
// come from a sample-counting vote over that log and an LFSR sequence model.
// ---------------------------------------------------------------------------
module tb_puf_challenge_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       load_seed = 1'b0;
   logic [7:0] seed = 8'h00;
   logic [7:0] puf_challenge;
   logic       puf_pulse;
   logic [7:0] puf_response = 8'h00;
   logic       busy;

   puf_challenge_sequencer_if resp_if ();

   int compared = 0;
   int mismatched = 0;

   // PUF model configuration, written only by the test tasks.
   int         puf_mode = 0;
   logic [7:0] puf_const = 8'h00;
   int         toggle_origin = 0;
   logic [7:0] rnd_base = 8'h00;
   logic [7:0] rnd_mask = 8'h00;

   // PUF model state, written only by the model process.
   int         pulse_total = 0;
   logic [7:0] sample_log [0:1023];

   puf_challenge_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .continuous    (continuous),
      .load_seed     (load_seed),
      .seed          (seed),
      .puf_challenge (puf_challenge),
      .puf_pulse     (puf_pulse),
      .puf_response  (puf_response),
      .busy          (busy),
      .resp          (resp_if)
   );

   always #5 clk = ~clk;

   // The PUF answers each excitation pulse with a new response: a constant,
   // a bit0 that alternates 1,0,1,... from a chosen origin, or random bits
   // around a base with only the masked bits allowed to flip.
   always @(posedge puf_pulse) begin
      int diff;
      diff = pulse_total - toggle_origin;
      case (puf_mode)
         0:       puf_response = puf_const;
         1:       puf_response = {7'b0000000, ~diff[0]};
         default: puf_response = rnd_base ^ (8'($urandom) & rnd_mask);
      endcase
      sample_log[pulse_total % 1024] = puf_response;
      pulse_total = pulse_total + 1;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   // Vote over seven logged samples starting at index first.
   task automatic model_result(input int first, output logic [7:0] d, output logic [7:0] u);
      int cnt;
      d = 8'h00;
      u = 8'h00;
      for (int b = 0; b < 8; b++) begin
         cnt = 0;
         for (int s = 0; s < 7; s++) begin
            if (sample_log[(first + s) % 1024][b]) cnt++;
         end
         d[b] = (cnt >= 4);
         u[b] = (cnt > 0) && (cnt < 7);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      load_seed = 1'b0;
      continuous = 1'b0;
      resp_if.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Leaves the bench at the negedge following the edge that took start.
   task automatic start_run();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      int n = 0;
      while (!resp_if.resp_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = resp_if.resp_valid;
   endtask

   task automatic finish_transfer(input logic cont);
      @(negedge clk);
      continuous = cont;
      resp_if.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_if.resp_ready = 1'b0;
      continuous = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_busy: got %b want 0", busy);
      end
      compared++;
      if (puf_pulse !== 1'b0 || resp_if.resp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_pulse_valid: got pulse=%b valid=%b want 0/0", puf_pulse, resp_if.resp_valid);
      end
      compared++;
      if (puf_challenge !== 8'h00 || resp_if.resp_data !== 8'h00 ||
          resp_if.resp_challenge !== 8'h00 || resp_if.resp_unstable !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got chal=%h data=%h rchal=%h unst=%h want all 00",
                  puf_challenge, resp_if.resp_data, resp_if.resp_challenge, resp_if.resp_unstable);
      end
   endtask

   task automatic test_first_measurement();
      int   cyc = 0;
      int   pulses = 0;
      int   high_len = 0;
      int   low_len = 0;
      int   bad_high = 0;
      int   bad_gap = 0;
      logic prev = 1'b0;
      do_reset();
      puf_mode = 0;
      puf_const = 8'hA5;
      start_run();
      compared++;
      if (puf_challenge !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL first_challenge: got %h want 01", puf_challenge);
      end
      forever begin
         if (puf_pulse) begin
            if (!prev) begin
               pulses++;
               if (low_len < 4) bad_gap++;
               high_len = 0;
            end
            high_len++;
         end else begin
            if (prev) begin
               if (high_len != 2) bad_high++;
               low_len = 0;
            end
            low_len++;
         end
         prev = puf_pulse;
         if (resp_if.resp_valid || cyc >= 200) break;
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (resp_if.resp_valid !== 1'b1 || cyc != 68) begin
         mismatched++;
         $display("[TB] FAIL latency: got valid=%b after %0d cycles want valid=1 after 68", resp_if.resp_valid, cyc);
      end
      compared++;
      if (pulses != 7) begin
         mismatched++;
         $display("[TB] FAIL pulse_count: got %0d want 7", pulses);
      end
      compared++;
      if (bad_high != 0 || bad_gap != 0) begin
         mismatched++;
         $display("[TB] FAIL pulse_shape: got %0d bad widths, %0d short gaps want 0/0", bad_high, bad_gap);
      end
      compared++;
      if (resp_if.resp_data !== 8'hA5 || resp_if.resp_unstable !== 8'h00 || resp_if.resp_challenge !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL const_result: got data=%h unst=%h chal=%h want A5/00/01",
                  resp_if.resp_data, resp_if.resp_unstable, resp_if.resp_challenge);
      end
      finish_transfer(1'b0);
      compared++;
      if (resp_if.resp_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL after_transfer: got valid=%b busy=%b want 0/0", resp_if.resp_valid, busy);
      end
   endtask

   task automatic test_continuous();
      logic [7:0] exp_chal = 8'h01;
      int         idle_seen = 0;
      int         n;
      do_reset();
      puf_mode = 0;
      puf_const = 8'h5A;
      resp_if.resp_ready = 1'b1;
      continuous = 1'b1;
      start_run();
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (!busy) idle_seen++;
         end while (!resp_if.resp_valid && n < 200);
         compared++;
         if (resp_if.resp_valid !== 1'b1 || resp_if.resp_challenge !== exp_chal || resp_if.resp_data !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL continuous_%0d: got valid=%b chal=%h data=%h want 1/%h/5A",
                     k, resp_if.resp_valid, resp_if.resp_challenge, resp_if.resp_data, exp_chal);
         end
         if (k == 3) continuous = 1'b0;
         exp_chal = lfsr_step(exp_chal);
      end
      @(negedge clk);
      resp_if.resp_ready = 1'b0;
      compared++;
      if (idle_seen != 0) begin
         mismatched++;
         $display("[TB] FAIL continuous_no_idle: got %0d idle cycles want 0", idle_seen);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL continuous_stop: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_toggle();
      bit ok;
      do_reset();
      puf_mode = 1;
      toggle_origin = pulse_total;
      start_run();
      wait_valid(200, ok);
      compared++;
      if (!ok || resp_if.resp_data !== 8'h01 || resp_if.resp_unstable !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL toggle_vote: got valid=%b data=%h unst=%h want 1/01/01",
                  resp_if.resp_valid, resp_if.resp_data, resp_if.resp_unstable);
      end
      finish_transfer(1'b0);
   endtask

   task automatic test_seed();
      bit ok;
      do_reset();
      puf_mode = 0;
      puf_const = 8'hC3;
      @(negedge clk);
      load_seed = 1'b1;
      seed = 8'h00;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_seed = 1'b0;
      start = 1'b0;
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL seed_start_ignored: got busy=%b want 0", busy);
      end
      start_run();
      compared++;
      if (puf_challenge !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL zero_seed: got %h want 01", puf_challenge);
      end
      repeat (5) begin
         @(negedge clk);
         load_seed = 1'b1;
         seed = 8'h3C;
         start = 1'b1;
      end
      @(negedge clk);
      load_seed = 1'b0;
      start = 1'b0;
      wait_valid(200, ok);
      compared++;
      if (!ok || resp_if.resp_challenge !== 8'h01 || resp_if.resp_data !== 8'hC3) begin
         mismatched++;
         $display("[TB] FAIL busy_seed_result: got valid=%b chal=%h data=%h want 1/01/C3",
                  resp_if.resp_valid, resp_if.resp_challenge, resp_if.resp_data);
      end
      finish_transfer(1'b0);
      start_run();
      compared++;
      if (puf_challenge !== lfsr_step(8'h01)) begin
         mismatched++;
         $display("[TB] FAIL busy_seed_ignored: got %h want %h", puf_challenge, lfsr_step(8'h01));
      end
      wait_valid(200, ok);
      finish_transfer(1'b0);
   endtask

   task automatic test_backpressure_and_reset();
      bit         ok;
      int         unstable_cycles = 0;
      int         n = 0;
      logic [7:0] d0, u0, c0;
      do_reset();
      puf_mode = 0;
      puf_const = 8'h3C;
      start_run();
      wait_valid(200, ok);
      d0 = resp_if.resp_data;
      u0 = resp_if.resp_unstable;
      c0 = resp_if.resp_challenge;
      repeat (10) begin
         @(negedge clk);
         if (resp_if.resp_valid !== 1'b1 || resp_if.resp_data !== d0 ||
             resp_if.resp_unstable !== u0 || resp_if.resp_challenge !== c0) unstable_cycles++;
      end
      compared++;
      if (!ok || unstable_cycles != 0 || d0 !== 8'h3C || c0 !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL hold_stable: got valid=%b changes=%0d data=%h chal=%h want 1/0/3C/01",
                  ok, unstable_cycles, d0, c0);
      end
      finish_transfer(1'b0);
      compared++;
      if (resp_if.resp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL hold_release: got valid=%b want 0", resp_if.resp_valid);
      end
      start_run();
      compared++;
      if (puf_challenge !== 8'hB8) begin
         mismatched++;
         $display("[TB] FAIL hold_lfsr_once: got %h want B8", puf_challenge);
      end
      while (!puf_pulse && n < 100) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (puf_pulse !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reach_pulse: got pulse=%b want 1", puf_pulse);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (puf_pulse !== 1'b0 || busy !== 1'b0 || resp_if.resp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_reset: got pulse=%b busy=%b valid=%b want 0/0/0",
                  puf_pulse, busy, resp_if.resp_valid);
      end
      rst = 1'b0;
      start_run();
      compared++;
      if (puf_challenge !== 8'h01) begin
         mismatched++;
         $display("[TB] FAIL abort_lfsr: got %h want 01", puf_challenge);
      end
      wait_valid(200, ok);
      finish_transfer(1'b0);
   endtask

   task automatic test_back_to_back();
      bit         ok;
      logic [7:0] exp_chal;
      logic [7:0] exp_d, exp_u;
      int         rd_ptr;
      int         first_ptr;
      logic       cont;
      do_reset();
      exp_chal = 8'($urandom_range(1, 255));
      @(negedge clk);
      load_seed = 1'b1;
      seed = exp_chal;
      @(negedge clk);
      load_seed = 1'b0;
      puf_mode = 2;
      rnd_base = 8'($urandom);
      rnd_mask = 8'($urandom);
      rd_ptr = pulse_total;
      first_ptr = rd_ptr;
      start_run();
      for (int m = 0; m < 6; m++) begin
         wait_valid(200, ok);
         model_result(rd_ptr, exp_d, exp_u);
         rd_ptr += 7;
         compared++;
         if (!ok || resp_if.resp_challenge !== exp_chal || resp_if.resp_data !== exp_d ||
             resp_if.resp_unstable !== exp_u || (pulse_total - first_ptr) != 7 * (m + 1)) begin
            mismatched++;
            $display("[TB] FAIL random_%0d: got valid=%b chal=%h data=%h unst=%h pulses=%0d want 1/%h/%h/%h/%0d",
                     m, resp_if.resp_valid, resp_if.resp_challenge, resp_if.resp_data,
                     resp_if.resp_unstable, pulse_total - first_ptr, exp_chal, exp_d, exp_u, 7 * (m + 1));
         end
         repeat ($urandom_range(0, 4)) @(negedge clk);
         rnd_base = 8'($urandom);
         rnd_mask = 8'($urandom);
         cont = (m < 5);
         finish_transfer(cont);
         exp_chal = lfsr_step(exp_chal);
         if (cont) begin
            compared++;
            if (busy !== 1'b1 || puf_challenge !== exp_chal) begin
               mismatched++;
               $display("[TB] FAIL random_next_%0d: got busy=%b chal=%h want 1/%h", m, busy, puf_challenge, exp_chal);
            end
         end
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL random_end: got busy=%b want 0", busy);
      end
   endtask

   initial begin
      resp_if.resp_ready = 1'b0;
      test_reset();
      test_first_measurement();
      test_continuous();
      test_toggle();
      test_seed();
      test_backpressure_and_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
